// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 4x4 keypad by column, debounces presses and releases,
// and reports one accepted key at a time.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   row_sync   keypad rows (pre-synchronized), 1 = key pressed in driven column
//   col_drive  one-hot active-high column drive
//   key_valid  one-cycle pulse on a debounced new press
//   key_code   {col_idx, row_idx} of the last accepted key, held until the next accept
//   key_held   high while the accepted key stays pressed
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV        = 48000,
  parameter int unsigned DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_sync,
  output logic [3:0] col_drive,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DbLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        col_drive_q, col_drive_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_held_q, key_held_d;

  logic              row_bit;
  logic [1:0]        low_row;

  assign row_bit = row_sync[row_idx_q];

  // Lowest set row wins when several rows are active at the sample.
  always_comb begin
    low_row = 2'd0;
    if (row_sync[0])      low_row = 2'd0;
    else if (row_sync[1]) low_row = 2'd1;
    else if (row_sync[2]) low_row = 2'd2;
    else if (row_sync[3]) low_row = 2'd3;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      StScan: begin
        if (cnt_q == ScanLast) begin
          cnt_d = '0;
          if (|row_sync) begin
            // Keep the column frozen while the candidate key is debounced.
            row_idx_d = low_row;
            state_d   = StDebounce;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StDebounce: begin
        if (row_bit) begin
          if (cnt_q == DbLast) begin
            cnt_d       = '0;
            state_d     = StHeld;
            key_valid_d = 1'b1;
            key_code_d  = {col_idx_q, row_idx_q};
            key_held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          cnt_d     = '0;
          state_d   = StScan;
          col_idx_d = col_idx_q + 2'd1;
        end
      end

      StHeld: begin
        if (!row_bit) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end

      StRelease: begin
        if (!row_bit) begin
          if (cnt_q == DbLast) begin
            cnt_d      = '0;
            state_d    = StScan;
            col_idx_d  = col_idx_q + 2'd1;
            key_held_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          // Release bounce: back to holding, no new pulse.
          cnt_d   = '0;
          state_d = StHeld;
        end
      end

      default: begin
        state_d = StScan;
        cnt_d   = '0;
      end
    endcase

    col_drive_d = 4'b0001 << col_idx_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StScan;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      col_drive_q <= 4'b0001;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'b0000;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      col_drive_q <= col_drive_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_drive = col_drive_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A small keypad model routes each column's pressed rows onto row_sync
// only while that column is driven.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] row_sync;
  logic [3:0] col_drive;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [3:0] keys [4];

  int n_checks;
  int n_errs;
  int pulses;
  int dbl;
  logic prev_kv;

  keypad_scan_ctrl #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .row_sync (row_sync),
    .col_drive(col_drive),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  assign row_sync = (col_drive[0] ? keys[0] : 4'b0) | (col_drive[1] ? keys[1] : 4'b0) |
                    (col_drive[2] ? keys[2] : 4'b0) | (col_drive[3] ? keys[3] : 4'b0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (key_valid) pulses++;
      if (key_valid && prev_kv) dbl++;
      prev_kv = key_valid;
    end else begin
      prev_kv = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) keys[i] = 4'b0;
    run(2);
    check_eq("rst_col", 32'(col_drive), 32'h1);
    check_eq("rst_kv", 32'(key_valid), 32'h0);
    check_eq("rst_code", 32'(key_code), 32'h0);
    check_eq("rst_held", 32'(key_held), 32'h0);
    pulses = 0;
    dbl    = 0;
    reset  = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    pulses   = 0;
    dbl      = 0;
    prev_kv  = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 4; i++) keys[i] = 4'b0;

    // Idle scan: column advances every 4 cycles.
    do_reset();
    check_eq("idle_col_0", 32'(col_drive), 32'h1);
    for (int n = 1; n <= 32; n++) begin
      logic [3:0] exp_col;
      run(1);
      exp_col = 4'b0001 << ((n / 4) % 4);
      check_eq("idle_col", 32'(col_drive), 32'(exp_col));
      check_eq("idle_kv", 32'(key_valid), 32'h0);
    end
    check_eq("idle_pulses", 32'(pulses), 32'h0);

    // Clean press in column 1, row 2: pulse after edge 16.
    do_reset();
    keys[1] = 4'b0100;
    run(15);
    check_eq("press_kv_early", 32'(key_valid), 32'h0);
    check_eq("press_col_frozen", 32'(col_drive), 32'h2);
    run(1);
    check_eq("press_kv", 32'(key_valid), 32'h1);
    check_eq("press_code", 32'(key_code), 32'h6);
    check_eq("press_held", 32'(key_held), 32'h1);
    run(1);
    check_eq("press_kv_one", 32'(key_valid), 32'h0);
    run(13);
    check_eq("press_pulses", 32'(pulses), 32'h1);
    check_eq("press_col_hold", 32'(col_drive), 32'h2);
    check_eq("press_held_hold", 32'(key_held), 32'h1);

    // Release bounce: low 5, high 2, then low until release completes.
    keys[1] = 4'b0000;
    run(5);
    check_eq("rel_held_low5", 32'(key_held), 32'h1);
    keys[1] = 4'b0100;
    run(2);
    check_eq("rel_held_bounce", 32'(key_held), 32'h1);
    keys[1] = 4'b0000;
    run(8);
    check_eq("rel_held_low8", 32'(key_held), 32'h1);
    run(4);
    check_eq("rel_held_fall", 32'(key_held), 32'h0);
    check_eq("rel_col_next", 32'(col_drive), 32'h4);
    check_eq("rel_pulses", 32'(pulses), 32'h1);
    check_eq("rel_code_kept", 32'(key_code), 32'h6);

    // Press bounce: high 3 in DEBOUNCE, low 1 -> back to SCAN on column 2.
    do_reset();
    keys[1] = 4'b0100;
    run(11);
    keys[1] = 4'b0000;
    run(1);
    check_eq("pb_col", 32'(col_drive), 32'h4);
    check_eq("pb_held", 32'(key_held), 32'h0);
    check_eq("pb_pulses", 32'(pulses), 32'h0);
    keys[1] = 4'b0100;
    run(23);
    check_eq("pb_kv_early", 32'(key_valid), 32'h0);
    run(1);
    check_eq("pb_kv", 32'(key_valid), 32'h1);
    check_eq("pb_code", 32'(key_code), 32'h6);
    run(2);
    check_eq("pb_pulses_one", 32'(pulses), 32'h1);

    // Multi-key in column 3 (rows 1 and 3) -> row 1 wins; then lockout.
    do_reset();
    keys[3] = 4'b1010;
    run(24);
    check_eq("mk_kv", 32'(key_valid), 32'h1);
    check_eq("mk_code", 32'(key_code), 32'hD);
    check_eq("mk_col", 32'(col_drive), 32'h8);
    keys[0] = 4'b0001;
    keys[3] = 4'b1011;
    run(12);
    check_eq("lock_col", 32'(col_drive), 32'h8);
    check_eq("lock_code", 32'(key_code), 32'hD);
    check_eq("lock_pulses", 32'(pulses), 32'h1);
    check_eq("lock_held", 32'(key_held), 32'h1);

    // Reset mid-DEBOUNCE at count 5.
    do_reset();
    keys[1] = 4'b0100;
    run(13);
    reset = 1'b0;
    run(1);
    check_eq("mdr_col", 32'(col_drive), 32'h1);
    check_eq("mdr_code", 32'(key_code), 32'h0);
    check_eq("mdr_kv", 32'(key_valid), 32'h0);
    check_eq("mdr_held", 32'(key_held), 32'h0);
    keys[1] = 4'b0000;
    reset   = 1'b1;
    run(3);
    check_eq("mdr_col0", 32'(col_drive), 32'h1);
    run(1);
    check_eq("mdr_col1", 32'(col_drive), 32'h2);
    check_eq("mdr_pulses", 32'(pulses), 32'h0);

    check_eq("no_double_pulse", 32'(dbl), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 48000, clk cycles each column is driven during scanning (min 2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 960000, consecutive stable clk cycles required to accept a press or a release (min 1).
REQ-003 clk  input  1  system clock; the block has one clock domain, and all logic SHALL be clocked on the rising edge of clk.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 row_sync  input  4  keypad rows, already synchronized externally; 1 = pressed key in the driven column.
REQ-006 col_drive  output  4  one-hot, active-high column drive.
REQ-007 key_valid  output  1  one-cycle pulse marking a debounced new press.
REQ-008 key_code  output  4  {col_idx[1:0], row_idx[1:0]} of the accepted key; held until the next accept.
REQ-009 key_held  output  1  high while an accepted key remains pressed (HELD and RELEASE states).

Function
REQ-010 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-011 SCAN: col_drive SHALL rotate 0001->0010->0100->1000->0001, advancing after SCAN_DIV cycles per column; the dwell counter wraps to 0 on advance.
REQ-012 SCAN: row_sync SHALL be sampled only on the last dwell cycle of each column; if nonzero, the FSM latches col_idx and the lowest-index set row and enters DEBOUNCE, without advancing the column.
REQ-013 Multiple rows set at a sample: lowest row index wins; other rows are ignored.
REQ-014 DEBOUNCE: col_drive SHALL stay frozen; the counter increments each cycle the latched row bit is 1.
REQ-015 DEBOUNCE: if the latched row bit reads 0, the counter clears and the FSM returns to SCAN, driving the next column with a fresh dwell; no pulse is issued.
REQ-016 DEBOUNCE: on the DEBOUNCE_CYCLES-th consecutive 1, the next cycle SHALL assert key_valid for exactly one cycle, update key_code, and enter HELD.
REQ-017 HELD: col_drive frozen; key_held=1; changes on other rows or columns are ignored (lockout, no further key_valid).
REQ-018 HELD: when the latched row bit reads 0, the FSM enters RELEASE with the counter cleared.
REQ-019 RELEASE: the counter increments each cycle the latched row bit is 0; on reaching DEBOUNCE_CYCLES, the FSM enters SCAN on the next column, and key_held falls in that same transition.
REQ-020 RELEASE: if the latched row bit reads 1 before the count completes, the FSM returns to HELD, clears the counter and issues no new key_valid (bounce on release).
REQ-021 Counters SHALL be sized ceil(log2(max(SCAN_DIV, DEBOUNCE_CYCLES)+1)) bits and SHALL never wrap within a state.
REQ-022 key_valid SHALL never assert in two consecutive cycles, and at most once per HELD entry.
REQ-023 Outputs SHALL be registered (no combinational path from row_sync to any output).

Reset
REQ-024 While reset=0 at a rising edge, the block SHALL enter SCAN with col_drive=0001, all counters=0, key_valid=0, key_code=0000, key_held=0.
REQ-025 Reset asserted in any state, including mid-debounce or HELD, SHALL abort with no key_valid pulse; after release, scanning restarts at column 0.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-026 Idle: reset then row_sync=0 for 32 cycles -> col_drive cycles 0001,0010,0100,1000 every 4 cycles; key_valid never asserts.
REQ-027 Clean press: row_sync=0100 while col_drive=0010, held 30 cycles -> exactly one key_valid, key_code=0110, col_drive frozen at 0010, key_held=1.
REQ-028 Press bounce: row bit high 3 cycles, low 1, then high -> return to SCAN on the low, no pulse; stable press on a later pass -> a single pulse.
REQ-029 Release bounce: after an accept, row low 5 cycles, high 2, low 8 -> key_held stays 1 through the bounce, then falls; only one key_valid in total.
REQ-030 Multi-key/lockout: row_sync=1010 in column 3 -> key_code=1101; while HELD, another column's key is pressed -> no pulse, col_drive unchanged.
REQ-031 Reset mid-DEBOUNCE at count 5 -> no pulse, col_drive=0001, key_code=0000 on the cycle after reset.
